mem_io_responder: RTL and testbench



---
 rtl/mem_io_responder.sv | 118 +++++++++++
 tb/tb_mem_io_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte RAM plus UART/counter/stop I/O page behind the CPU memory bus
// Every cycle is one access; read data is registered and returned the following cycle.
module mem_io_responder #(
  parameter int ADDR_BITS   = 17,
  parameter     INIT_FILE   = "",
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_stop,
  output logic        tx_overflow
);
  localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CNT_W = $clog2(TX_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(TX_DEPTH - FULL_MARGIN);

  logic [17:0] addr;
  logic        unused_addr_hi;
  logic        io, io_rx, io_cnt;

  assign addr           = mem_a[17:0];
  assign unused_addr_hi = ^mem_a[31:18];
  assign io             = (addr[17:16] == 2'b11);
  assign io_rx          = io && (addr[15:0] == 16'h0000);
  assign io_cnt         = io && (addr[15:0] == 16'h0004);

  logic [7:0] ram [0:(1 << ADDR_BITS)-1];

  always_ff @(posedge clk_in) begin
    if (mem_wr && !io) ram[mem_a[ADDR_BITS-1:0]] <= mem_dout;
  end

  logic [31:0] cycle_cnt;
  logic [31:0] snapshot;
  logic [7:0]  rd_data;

  // Bytes 1..3 come from the snapshot taken at 0x30004 so a 4-byte read is coherent.
  always_comb begin
    rd_data = 8'h00;
    if (!io) begin
      rd_data = ram[mem_a[ADDR_BITS-1:0]];
    end else begin
      case (addr[15:0])
        16'h0000: rd_data = rx_valid ? rx_data : 8'h00;
        16'h0004: rd_data = cycle_cnt[7:0];
        16'h0005: rd_data = snapshot[15:8];
        16'h0006: rd_data = snapshot[23:16];
        16'h0007: rd_data = snapshot[31:24];
        default:  rd_data = 8'h00;
      endcase
    end
  end

  assign rx_ready = !rst_in && !mem_wr && io_rx && rx_valid;

  logic [7:0]       fifo [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             full, pop, push_req, push;

  assign full     = (count == DEPTH_C);
  assign tx_valid = (count != '0);
  assign tx_data  = fifo[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push_req = mem_wr && io_rx && (mem_dout != 8'h00);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo[wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din        <= 8'h00;
      cycle_cnt      <= 32'd0;
      snapshot       <= 32'd0;
      sim_stop       <= 1'b0;
      tx_overflow    <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      mem_din   <= mem_wr ? 8'h00 : rd_data;
      if (!mem_wr && io_cnt) snapshot <= cycle_cnt;
      if (mem_wr && io_cnt) sim_stop <= 1'b1;
      if (push_req && full && !pop) tx_overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count          <= count_nxt;
      io_buffer_full <= (count_nxt >= THRESH_C);
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed vector table plus hand sequences for mem_io_responder
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        sim_stop;
  logic        tx_overflow;

  int errors = 0;
  int checks = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sim_stop(sim_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  dout;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [7:0]  e_din;
    logic        e_rxr;
    logic        e_txv;
    logic [7:0]  e_txd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic [31:0] a, input logic [7:0] dout,
                     input logic rxv, input logic [7:0] rxd, input logic txr,
                     input logic [7:0] e_din, input logic e_rxr, input logic e_txv,
                     input logic [7:0] e_txd);
    vec_t v;
    v.wr = wr; v.a = a; v.dout = dout; v.rxv = rxv; v.rxd = rxd; v.txr = txr;
    v.e_din = e_din; v.e_rxr = e_rxr; v.e_txv = e_txv; v.e_txd = e_txd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr = wr; mem_a = a; mem_dout = d;
  endtask

  logic [31:0] dword;
  logic [7:0]  exp_drain [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h0;
    tx_ready = 1'b1; rx_data = 8'h0; rx_valid = 1'b0;

    //     wr  addr          dout  rxv rxd   txr  e_din e_rxr e_txv e_txd
    add(1'b1, 32'h0001_0, 8'hA5, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    add(1'b1, 32'h0001_FFFF, 8'h5C, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5C, 1'b0, 1'b0, 8'h00);
    add(1'b1, 32'h0000_0000, 8'h11, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    add(1'b1, 32'h0001_0000, 8'h77, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0001_0000, 8'h00, 1'b1, 8'h37, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0002_0000, 8'h00, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'hFFF0_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h37, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h37, 1'b1, 8'h37, 1'b1, 1'b0, 8'h00);
    add(1'b1, 32'h0003_0000, 8'h41, 1'b1, 8'h37, 1'b1, 8'h00, 1'b0, 1'b1, 8'h41);
    add(1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b1, 32'h0003_0000, 8'h42, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h42);
    add(1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0003_0001, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 32'h0003_0008, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b1, 32'h0003_0008, 8'h55, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[0].a = 32'h0000_0010;

    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("reset mem_din", mem_din, 8'h00);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset io_buffer_full", io_buffer_full, 1'b0);
    chk("reset sim_stop", sim_stop, 1'b0);
    chk("reset tx_overflow", tx_overflow, 1'b0);
    rst_in = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].a, vecs[i].dout);
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd; tx_ready = vecs[i].txr;
      #1;
      chk($sformatf("v%0d rx_ready", i), rx_ready, vecs[i].e_rxr);
      @(posedge clk_in);
      #1;
      chk($sformatf("v%0d mem_din", i), mem_din, vecs[i].e_din);
      chk($sformatf("v%0d tx_valid", i), tx_valid, vecs[i].e_txv);
      if (vecs[i].e_txv) chk($sformatf("v%0d tx_data", i), tx_data, vecs[i].e_txd);
    end
    rx_valid = 1'b0;

    // Fill the FIFO with the sink stalled, then push on a full FIFO with and without a pop.
    tx_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'h0003_0000, 8'(8'h0F + k));
      step();
      chk($sformatf("fill%0d io_buffer_full", k), io_buffer_full, (k >= 6));
      chk($sformatf("fill%0d tx_data", k), tx_data, 8'h10);
      chk($sformatf("fill%0d tx_overflow", k), tx_overflow, 1'b0);
    end
    tx_ready = 1'b1;
    drive(1'b1, 32'h0003_0000, 8'h18);
    step();
    chk("full push+pop tx_data", tx_data, 8'h11);
    chk("full push+pop io_buffer_full", io_buffer_full, 1'b1);
    chk("full push+pop tx_overflow", tx_overflow, 1'b0);
    tx_ready = 1'b0;
    drive(1'b1, 32'h0003_0000, 8'h19);
    step();
    chk("full drop tx_overflow", tx_overflow, 1'b1);
    chk("full drop tx_data", tx_data, 8'h11);

    drive(1'b0, 32'h0000_0010, 8'h00);
    tx_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d tx_valid", j), tx_valid, 1'b1);
      chk($sformatf("drain%0d tx_data", j), tx_data, exp_drain[j]);
      step();
      chk($sformatf("drain%0d io_buffer_full", j), io_buffer_full, ((7 - j) >= 6));
    end
    chk("drained tx_valid", tx_valid, 1'b0);
    chk("tx_overflow sticky", tx_overflow, 1'b1);

    drive(1'b1, 32'h0003_0004, 8'h00);
    step();
    chk("sim_stop set", sim_stop, 1'b1);
    drive(1'b0, 32'h0000_0000, 8'h00);
    step();
    chk("sim_stop sticky", sim_stop, 1'b1);
    tx_ready = 1'b0;
    drive(1'b1, 32'h0003_0000, 8'h55);
    step();
    chk("pre-reset tx_valid", tx_valid, 1'b1);
    drive(1'b0, 32'h0000_0010, 8'h00);
    step();
    chk("pre-reset mem_din", mem_din, 8'hA5);

    // Asynchronous reset in the middle of a cycle with a read in flight.
    #2 rst_in = 1'b1;
    #1;
    chk("async rst mem_din", mem_din, 8'h00);
    chk("async rst tx_valid", tx_valid, 1'b0);
    chk("async rst sim_stop", sim_stop, 1'b0);
    chk("async rst tx_overflow", tx_overflow, 1'b0);
    chk("async rst io_buffer_full", io_buffer_full, 1'b0);
    #1 rst_in = 1'b0;

    repeat (100) @(posedge clk_in);
    #1;
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 32'h0003_0004 + 32'(b), 8'h00);
      step();
      dword[8*b +: 8] = mem_din;
    end
    chk("counter dword at 100", dword, 32'd100);

    repeat (152) @(posedge clk_in);
    #1;
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 32'h0003_0004 + 32'(b), 8'h00);
      step();
      dword[8*b +: 8] = mem_din;
    end
    chk("counter dword at 256", dword, 32'd256);

    drive(1'b0, 32'h0000_0010, 8'h00);
    step();
    chk("ram kept over reset", mem_din, 8'hA5);
    chk("fifo empty after reset", tx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
